// File: rtl/display_pkg.sv
// Shared constants and types for the binary-to-BCD display path.
package display_pkg;

    localparam int NUM_DIGITS  = 4;
    localparam int BCD_W       = 16;
    localparam int SHIFT_CNT   = 14;
    localparam int MAX_DISPLAY = 9999;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } bcd_state_e;

    typedef logic [NUM_DIGITS-1:0][3:0] bcd4_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adjust (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // Per-digit add-3 correction applied before every shift
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= 4'd5) begin
            digit_out = digit_in + 4'd3;
        end else begin
            digit_out = digit_in;
        end
    end

endmodule

// File: rtl/display_bcd_converter.sv
// Iterative shift-and-add-3 binary-to-BCD converter with saturation, feeding
// the seven-segment display's displayed_number input.
module display_bcd_converter
    import display_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int SAT_MAX = MAX_DISPLAY
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_value,
    output logic [15:0]     bcd_out,
    output logic            bcd_valid,
    output logic            overflow
);

    bcd_state_e        state_r;
    bcd_state_e        state_next_s;
    logic [13:0]       bin_r;
    logic              ovf_r;
    bcd4_t             scratch_r;
    logic [3:0]        cnt_r;
    bcd4_t             adj_s;
    logic [BCD_W-1:0]  adj_flat_s;
    logic [BCD_W-1:0]  shifted_s;
    logic              over_s;
    logic [13:0]       clamp_s;
    logic              last_s;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_in  (scratch_r[g]),
            .digit_out (adj_s[g])
        );
    end

    assign in_ready = (state_r == IDLE);

    // Saturation is decided on the full-width input before truncation to 14 bits
    always_comb begin
        over_s     = (in_value > IN_W'(SAT_MAX));
        clamp_s    = in_value[13:0];
        adj_flat_s = adj_s;
        shifted_s  = {adj_flat_s[BCD_W-2:0], bin_r[13]};
        last_s     = (cnt_r == 4'(SHIFT_CNT - 1));
        if (over_s) begin
            clamp_s = 14'(SAT_MAX);
        end else begin
            clamp_s = in_value[13:0];
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State and working registers; outputs only move on the completion edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            bin_r     <= 14'd0;
            ovf_r     <= 1'b0;
            scratch_r <= '0;
            cnt_r     <= 4'd0;
            bcd_out   <= 16'h0000;
            bcd_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            bcd_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        bin_r     <= clamp_s;
                        ovf_r     <= over_s;
                        scratch_r <= '0;
                        cnt_r     <= 4'd0;
                    end
                end
                SHIFT: begin
                    scratch_r <= shifted_s;
                    bin_r     <= {bin_r[12:0], 1'b0};
                    cnt_r     <= cnt_r + 4'd1;
                    if (last_s) begin
                        bcd_out   <= shifted_s;
                        overflow  <= ovf_r;
                        bcd_valid <= 1'b1;
                    end
                end
                default: begin
                    scratch_r <= '0;
                    cnt_r     <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_bcd_converter.sv
// Self-checking bench: randomized and directed requests against a decimal model.
module tb_display_bcd_converter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_value = 16'd0;
    logic [15:0] bcd_out;
    logic        bcd_valid;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    display_bcd_converter #(.IN_W(16), .SAT_MAX(9999)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .bcd_out   (bcd_out),
        .bcd_valid (bcd_valid),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a countdown of busy cycles and the decimal value in flight.
    int          m_busy  = 0;
    int          m_pend  = 0;
    logic        m_povf  = 1'b0;
    logic [15:0] m_bcd   = 16'h0000;
    logic        m_ovf   = 1'b0;
    logic        m_valid = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_bcd = 16'h0000; m_ovf = 1'b0; m_valid = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_bcd = to_bcd(m_pend); m_ovf = m_povf; m_valid = 1'b1;
                end
            end else if (in_valid) begin
                m_pend = (int'(in_value) > 9999) ? 9999 : int'(in_value);
                m_povf = (int'(in_value) > 9999);
                m_busy = 14;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("ready", in_ready, (m_busy == 0));
        check("valid", bcd_valid, m_valid);
        check("bcd_out", bcd_out, m_bcd);
        check("overflow", overflow, m_ovf);
    end

    task automatic wait_result(input string name, output bit got);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bcd_valid) got = 1'b1;
        end
        if (!got) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic convert(input logic [15:0] v, input logic [15:0] exp_bcd, input logic exp_ovf, input string name);
        bit got;
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 40) begin @(negedge clk); waited++; end
        in_valid = 1'b1; in_value = v;
        @(negedge clk);
        in_valid = 1'b0; in_value = $urandom_range(0, 65535);
        wait_result(name, got);
        if (got) begin
            check({name, "_bcd"}, bcd_out, exp_bcd);
            check({name, "_ovf"}, overflow, exp_ovf);
        end
    endtask

    initial begin
        bit got;
        int pulses;
        check("model_1234", to_bcd(1234), 16'h1234);
        check("model_0907", to_bcd(907), 16'h0907);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", in_ready, 1'b1);
        check("rst_bcd", bcd_out, 16'h0000);
        check("rst_valid", bcd_valid, 1'b0);
        check("rst_ovf", overflow, 1'b0);

        convert(16'd0,     16'h0000, 1'b0, "zero");
        convert(16'd1234,  16'h1234, 1'b0, "d1234");
        convert(16'd9999,  16'h9999, 1'b0, "d9999");
        convert(16'd10000, 16'h9999, 1'b1, "d10000");
        convert(16'hFFFF,  16'h9999, 1'b1, "dFFFF");
        convert(16'd16384, 16'h9999, 1'b1, "d16384");

        // held in_valid: 42 then 7, input change mid-conversion ignored
        @(negedge clk);
        in_valid = 1'b1; in_value = 16'd42;
        repeat (3) @(negedge clk);
        in_value = 16'd7;
        wait_result("held42", got);
        if (got) check("held42_bcd", bcd_out, 16'h0042);
        wait_result("held7", got);
        if (got) check("held7_bcd", bcd_out, 16'h0007);
        in_valid = 1'b0;

        // reset in the middle of a conversion of 5678
        @(negedge clk);
        in_valid = 1'b1; in_value = 16'd5678;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_bcd", bcd_out, 16'h0000);
        check("midrst_valid", bcd_valid, 1'b0);
        check("midrst_ovf", overflow, 1'b0);
        check("midrst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (20) begin @(negedge clk); if (bcd_valid) pulses++; end
        check("midrst_nopulse", pulses, 0);
        convert(16'd5678, 16'h5678, 1'b0, "d5678");

        // randomized traffic, checked every cycle by the model compare
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: in_value = 16'($urandom_range(0, 9999));
                1: in_value = 16'($urandom_range(9990, 10010));
                2: in_value = 16'($urandom_range(0, 65535));
                default: in_value = 16'($urandom_range(0, 99));
            endcase
        end
        in_valid = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/display_bcd_converter.md
# display_bcd_converter

Sequential binary-to-BCD converter that sits directly upstream of the four-digit seven-segment display top. It accepts a 16-bit unsigned binary value over a valid/ready handshake and converts it with an iterative shift-and-add-3 (double-dabble) algorithm. It drives a stable 16-bit packed BCD word, four nibbles with the thousands digit in [15:12], into the display's `displayed_number` input. Values above 9999 saturate, and an overflow flag is raised.

## Interface

Parameters:
- `IN_W`, default 16: input width. Must be ≤ 32 and ≥ 14.
- `SAT_MAX`, default 9999: largest displayable value. Inputs above it are clamped to it.

Ports:
- `clk` in 1: single clock domain, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: `in_value` is offered.
- `in_ready` out 1: converter can accept. It is high exactly in state IDLE.
- `in_value` in `IN_W`: unsigned binary value to display.
- `bcd_out` out 16: packed BCD result, held between conversions. It feeds `displayed_number`.
- `bcd_valid` out 1: one-cycle pulse when `bcd_out` has just been updated.
- `overflow` out 1: last accepted value exceeded `SAT_MAX`. Held with `bcd_out`.

## Operation

States: IDLE, SHIFT.

IDLE:
- `in_ready`=1.
- On `in_valid && in_ready`, the block loads the working registers and moves to SHIFT:
  - `bin_q` (14 bits) gets min(`in_value`, `SAT_MAX`).
  - `ovf_q` gets (`in_value` > `SAT_MAX`).
  - `scratch_q` (16 bits) gets 0.
  - `cnt_q` gets 0.

SHIFT:
- Each cycle, every nibble of `scratch_q` that is ≥ 5 gets +3. The adjustment is per digit and combinational.
- Then {`scratch_q`, `bin_q`} shifts left by one.
- `cnt_q` increments.
- When `cnt_q` == 13, this is the 14th shift. On that edge:
  - `bcd_out` gets the shifted scratch value.
  - `overflow` gets `ovf_q`.
  - `bcd_valid` gets 1.
  - State returns to IDLE.
- `in_valid` is ignored in SHIFT, and no input is queued.

General rules:
- `bcd_valid` deasserts on the following edge unless a new result completes on that edge.
- `bcd_out` and `overflow` change only on a completion edge. The display never sees intermediate scratch values.
- Arithmetic: nibble adjust is 4-bit unsigned and cannot exceed 4'hC before the shift. The saturation compare is done at full `IN_W` width before truncation to 14 bits.
- Bits of `in_value` above bit 13 are only used in the saturation compare.

## Timing

- Reset values:
  - State is IDLE, so `in_ready`=1.
  - `bcd_out`=16'h0000, `bcd_valid`=0, `overflow`=0, and all working registers are 0.
- `in_valid` is ignored while `rst` is high.
- Latency: the handshake is accepted at edge E0. Shifts occur at E1–E14. `bcd_out` is valid and `bcd_valid`=1 in the cycle after E14.
- Throughput: `in_ready` is high again after E14. A held `in_valid` is accepted at E15, so there is one conversion per 15 cycles.
- Reset mid-conversion:
  - All outputs return immediately, and asynchronously, to their reset values.
  - The in-flight conversion is discarded and no `bcd_valid` pulse is produced.
- A change of `in_value` during SHIFT has no effect.

## Structure

- Package `display_pkg` holds:
  - `NUM_DIGITS`=4, `BCD_W`=16, `SHIFT_CNT`=14, `MAX_DISPLAY`=9999.
  - `typedef enum logic {IDLE, SHIFT} bcd_state_e`.
  - The packed BCD typedef `bcd4_t` (`logic [3:0][3:0]`).
- One combinational sub-module, `bcd_digit_adjust` (4-bit in, 4-bit out, +3 when ≥ 5). It is instantiated `NUM_DIGITS` times.
- Top-level wiring: `display_bcd_converter.bcd_out` connects to the seven-segment top's `displayed_number`.

## Test plan

- Reset then `in_value`=0 with `in_valid`=1 for one cycle:
  - `in_ready`=0 for 14 cycles.
  - Then `bcd_out`=16'h0000, `bcd_valid` pulses once, `overflow`=0.
- `in_value`=1234: `bcd_out`=16'h1234 exactly 14 edges after acceptance. `bcd_out` must stay at its previous value through E1–E13.
- `in_value`=9999 → `bcd_out`=16'h9999, `overflow`=0.
- Out-of-range inputs, each → `bcd_out`=16'h9999, `overflow`=1:
  - `in_value`=10000
  - `in_value`=16'hFFFF
  - `in_value`=16384, where the low 14 bits are 0.
- `in_valid` held high:
  - 42 is accepted at E0. Changing `in_value` to 7 at E3 is ignored.
  - Result is 16'h0042. Then 7 is accepted at E15, giving 16'h0007 after E29.
- Assert `rst` at E7 of a conversion of 5678:
  - `bcd_out`=0, `bcd_valid`=0, `overflow`=0 and `in_ready`=1 immediately. No pulse follows.
  - The next request for 5678 completes normally with 16'h5678.
